// File: rtl/fc_credit_limit_tracker_if.sv
// rtl/fc_credit_limit_tracker_if.sv - DLLP receive bus and InitFC transmit-request handshake
// Purpose: bundles the decoded-DLLP strobe bus from the data link layer with the
//          InitFC request/acknowledge handshake toward the DLLP transmitter.
// Signals: dllp_valid/dllp_type/dllp_vc/dllp_hdr_fc/dllp_data_fc  link layer -> tracker
//          tx_init_req/tx_init_type                               tracker -> transmitter
//          tx_init_ack                                            transmitter -> tracker
// Modports: master = link layer / transmitter side, slave = credit tracker side.
interface fc_credit_limit_tracker_if #(
  parameter int HDR_W = 8,
  parameter int DAT_W = 12
);
  logic             dllp_valid;
  logic [3:0]       dllp_type;
  logic [2:0]       dllp_vc;
  logic [HDR_W-1:0] dllp_hdr_fc;
  logic [DAT_W-1:0] dllp_data_fc;
  logic             tx_init_req;
  logic [3:0]       tx_init_type;
  logic             tx_init_ack;

  modport master (
    output dllp_valid, dllp_type, dllp_vc, dllp_hdr_fc, dllp_data_fc, tx_init_ack,
    input  tx_init_req, tx_init_type
  );

  modport slave (
    input  dllp_valid, dllp_type, dllp_vc, dllp_hdr_fc, dllp_data_fc, tx_init_ack,
    output tx_init_req, tx_init_type
  );
endinterface

// File: rtl/fc_credit_limit_tracker.sv
// rtl/fc_credit_limit_tracker.sv - VC0 receive-side flow-control credit-limit tracker
// Purpose: decodes InitFC1/InitFC2/UpdateFC DLLPs, runs FC initialisation, holds the
//          six credit limits plus infinite-credit flags, and paces InitFC transmit requests.
// Ports: clk, rst (sync, active-high), link_up (DL_Up; low forces IDLE)
//        dl                      DLLP bus in, InitFC request/ack handshake (slave modport)
//        PH/NPH/CH_credit_limit  header credit limits
//        PD/NPD/CD_credit_limit  data credit limits
//        inf_flags               {CD,CH,NPD,NPH,PD,PH}, 1 = infinite
//        fc_init_done            registered, high in ACTIVE
//        fc_state                00 IDLE, 01 INIT1, 10 INIT2, 11 ACTIVE
//        protocol_err            one-cycle pulse on unexpected/malformed DLLP
module fc_credit_limit_tracker #(
  parameter int         HDR_W      = 8,
  parameter int         DAT_W      = 12,
  parameter logic [2:0] VC_ID      = 3'd0,
  parameter int         RESEND_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      link_up,
  fc_credit_limit_tracker_if.slave  dl,
  output logic [HDR_W-1:0]          PH_credit_limit,
  output logic [HDR_W-1:0]          NPH_credit_limit,
  output logic [HDR_W-1:0]          CH_credit_limit,
  output logic [DAT_W-1:0]          PD_credit_limit,
  output logic [DAT_W-1:0]          NPD_credit_limit,
  output logic [DAT_W-1:0]          CD_credit_limit,
  output logic [5:0]                inf_flags,
  output logic                      fc_init_done,
  output logic [1:0]                fc_state,
  output logic                      protocol_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_INIT1  = 2'b01,
    ST_INIT2  = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  localparam int CNT_W = $clog2(RESEND_CYC);

  state_t           state, state_nxt;
  // Indexed by the low two bits of the DLLP type (P=0, NP=1, Cpl=2); slot 3 never written.
  logic [HDR_W-1:0] hdr_lim [4];
  logic [DAT_W-1:0] dat_lim [4];
  logic [3:0]       inf_hdr, inf_dat, recorded, rec_nxt;
  logic [1:0]       tx_cls;
  logic             tx_wait;
  logic [CNT_W-1:0] tx_cnt;

  // DLLP decode: type[3:2] selects the DLLP kind, type[1:0] the credit class.
  logic       acc, cls_ok, is_i1, is_i2, is_upd;
  logic [1:0] cls;
  assign acc    = dl.dllp_valid && (dl.dllp_vc == VC_ID);
  assign cls    = dl.dllp_type[1:0];
  assign cls_ok = (cls != 2'd3);
  assign is_i1  = acc && cls_ok && (dl.dllp_type[3:2] == 2'b01);
  assign is_i2  = acc && cls_ok && (dl.dllp_type[3:2] == 2'b11);
  assign is_upd = acc && cls_ok && (dl.dllp_type[3:2] == 2'b10);

  logic init_load, upd_apply, err_seq, err_inf;

  always_comb begin
    state_nxt = state;
    init_load = 1'b0;
    upd_apply = 1'b0;
    err_seq   = 1'b0;
    rec_nxt   = recorded;
    case (state)
      ST_IDLE:   if (link_up) state_nxt = ST_INIT1;
      ST_INIT1: begin
        init_load = (is_i1 || is_i2) && !recorded[cls];
        err_seq   = is_upd;
        rec_nxt   = recorded | (init_load ? (4'b0001 << cls) : 4'b0000);
        if (rec_nxt[2:0] == 3'b111) state_nxt = ST_INIT2;
      end
      ST_INIT2: begin
        upd_apply = is_upd;
        if (is_i2 || is_upd) state_nxt = ST_ACTIVE;
      end
      default:   upd_apply = is_upd;
    endcase
    // Loss of DL_Up wins over any DLLP arriving in the same cycle.
    if (!link_up) begin
      state_nxt = ST_IDLE;
      init_load = 1'b0;
      upd_apply = 1'b0;
      err_seq   = 1'b0;
    end
  end

  // Infinite fields must be advertised as zero; the other field is still applied.
  assign err_inf = upd_apply &&
                   ((inf_hdr[cls] && (dl.dllp_hdr_fc  != '0)) ||
                    (inf_dat[cls] && (dl.dllp_data_fc != '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      fc_init_done <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      fc_init_done <= (state_nxt == ST_ACTIVE);
      protocol_err <= err_seq || err_inf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !link_up || (state == ST_IDLE)) begin
      for (int i = 0; i < 4; i++) begin
        hdr_lim[i] <= '0;
        dat_lim[i] <= '0;
      end
      inf_hdr  <= '0;
      inf_dat  <= '0;
      recorded <= '0;
    end else if (init_load) begin
      hdr_lim[cls]  <= dl.dllp_hdr_fc;
      dat_lim[cls]  <= dl.dllp_data_fc;
      inf_hdr[cls]  <= (dl.dllp_hdr_fc == '0);
      inf_dat[cls]  <= (dl.dllp_data_fc == '0);
      recorded[cls] <= 1'b1;
    end else if (upd_apply) begin
      if (!inf_hdr[cls]) hdr_lim[cls] <= dl.dllp_hdr_fc;
      if (!inf_dat[cls]) dat_lim[cls] <= dl.dllp_data_fc;
    end
  end

  // InitFC pacing: P, NP, Cpl each held until acked, then RESEND_CYC quiet cycles.
  // Any state change (including INIT1->INIT2) restarts the round at P.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state) ||
        !((state_nxt == ST_INIT1) || (state_nxt == ST_INIT2))) begin
      tx_cls  <= 2'd0;
      tx_wait <= 1'b0;
      tx_cnt  <= '0;
    end else if (tx_wait) begin
      if (tx_cnt == CNT_W'(RESEND_CYC - 1)) begin
        tx_wait <= 1'b0;
        tx_cnt  <= '0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end else if (dl.tx_init_ack) begin
      if (tx_cls == 2'd2) begin
        tx_cls  <= 2'd0;
        tx_wait <= 1'b1;
      end else begin
        tx_cls <= tx_cls + 2'd1;
      end
    end
  end

  assign dl.tx_init_req  = ((state == ST_INIT1) || (state == ST_INIT2)) && !tx_wait;
  assign dl.tx_init_type = dl.tx_init_req ?
                           {((state == ST_INIT2) ? 2'b11 : 2'b01), tx_cls} : 4'h0;

  assign fc_state         = state;
  assign PH_credit_limit  = hdr_lim[0];
  assign NPH_credit_limit = hdr_lim[1];
  assign CH_credit_limit  = hdr_lim[2];
  assign PD_credit_limit  = dat_lim[0];
  assign NPD_credit_limit = dat_lim[1];
  assign CD_credit_limit  = dat_lim[2];
  assign inf_flags        = {inf_dat[2], inf_hdr[2], inf_dat[1], inf_hdr[1],
                             inf_dat[0], inf_hdr[0]};

endmodule

// File: tb/tb_fc_credit_limit_tracker.sv
// tb/tb_fc_credit_limit_tracker.sv - self-checking bench for fc_credit_limit_tracker
module tb_fc_credit_limit_tracker;

  logic clk = 1'b0;
  logic rst;
  logic link_up;
  logic [7:0]  ph, nph, ch;
  logic [11:0] pd, npd, cd;
  logic [5:0]  inf_flags;
  logic        fc_init_done, protocol_err;
  logic [1:0]  fc_state;

  always #5 clk = ~clk;

  fc_credit_limit_tracker_if #(.HDR_W(8), .DAT_W(12)) dl ();

  fc_credit_limit_tracker #(
    .HDR_W(8), .DAT_W(12), .VC_ID(3'd0), .RESEND_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .link_up(link_up), .dl(dl.slave),
    .PH_credit_limit(ph), .NPH_credit_limit(nph), .CH_credit_limit(ch),
    .PD_credit_limit(pd), .NPD_credit_limit(npd), .CD_credit_limit(cd),
    .inf_flags(inf_flags), .fc_init_done(fc_init_done), .fc_state(fc_state),
    .protocol_err(protocol_err)
  );

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic        done;
    logic [7:0]  ph, nph, ch;
    logic [11:0] pd, npd, cd;
    logic [5:0]  inf;
    logic        err;
    logic        req;
    logic [3:0]  typ;
  } snap_t;

  snap_t exp_s;
  snap_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic compare_pop();
    snap_t e;
    e = sb.pop_front();
    chk({e.tag, "/state"}, 32'(fc_state), 32'(e.st));
    chk({e.tag, "/done"},  32'(fc_init_done), 32'(e.done));
    chk({e.tag, "/PH"},    32'(ph),  32'(e.ph));
    chk({e.tag, "/PD"},    32'(pd),  32'(e.pd));
    chk({e.tag, "/NPH"},   32'(nph), 32'(e.nph));
    chk({e.tag, "/NPD"},   32'(npd), 32'(e.npd));
    chk({e.tag, "/CH"},    32'(ch),  32'(e.ch));
    chk({e.tag, "/CD"},    32'(cd),  32'(e.cd));
    chk({e.tag, "/inf"},   32'(inf_flags), 32'(e.inf));
    chk({e.tag, "/err"},   32'(protocol_err), 32'(e.err));
    chk({e.tag, "/req"},   32'(dl.tx_init_req), 32'(e.req));
    chk({e.tag, "/type"},  32'(dl.tx_init_type), 32'(e.typ));
  endtask

  // Push the expectation for the stimulus now on the inputs, clock once, compare.
  task automatic cycle(input string tag);
    exp_s.tag = tag;
    sb.push_back(exp_s);
    @(posedge clk);
    #1;
    compare_pop();
    dl.dllp_valid  = 1'b0;
    dl.tx_init_ack = 1'b0;
    exp_s.err      = 1'b0;
  endtask

  task automatic send(input logic [3:0] t, input logic [2:0] vc,
                      input logic [7:0] h, input logic [11:0] d);
    dl.dllp_valid   = 1'b1;
    dl.dllp_type    = t;
    dl.dllp_vc      = vc;
    dl.dllp_hdr_fc  = h;
    dl.dllp_data_fc = d;
  endtask

  task automatic clear_exp();
    exp_s = '{tag: "", st: 2'b00, done: 1'b0, ph: 8'h0, nph: 8'h0, ch: 8'h0,
              pd: 12'h0, npd: 12'h0, cd: 12'h0, inf: 6'h0, err: 1'b0,
              req: 1'b0, typ: 4'h0};
  endtask

  initial begin
    rst = 1'b1;
    link_up = 1'b0;
    dl.dllp_valid = 1'b0; dl.dllp_type = 4'h0; dl.dllp_vc = 3'd0;
    dl.dllp_hdr_fc = 8'h0; dl.dllp_data_fc = 12'h0; dl.tx_init_ack = 1'b0;
    clear_exp();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("reset");

    // Bring-up and InitFC1 pacing
    link_up = 1'b1;
    exp_s.st = 2'b01; exp_s.req = 1'b1; exp_s.typ = 4'h4;
    cycle("link_up");
    dl.tx_init_ack = 1'b1; exp_s.typ = 4'h5; cycle("ack_p");
    dl.tx_init_ack = 1'b1; exp_s.typ = 4'h6; cycle("ack_np");
    dl.tx_init_ack = 1'b1; exp_s.req = 1'b0; exp_s.typ = 4'h0; cycle("ack_cpl");
    for (int i = 0; i < 63; i++) cycle("resend_gap");
    exp_s.req = 1'b1; exp_s.typ = 4'h4; cycle("resend_p");

    // Initialisation values
    send(4'h4, 3'd0, 8'h20, 12'h080);
    exp_s.ph = 8'h20; exp_s.pd = 12'h080; cycle("init1_p");
    send(4'h4, 3'd0, 8'h55, 12'h123); cycle("dup_init1_p");
    send(4'h8, 3'd0, 8'h44, 12'h044); exp_s.err = 1'b1; cycle("upd_in_init1");
    send(4'h5, 3'd0, 8'h10, 12'h000);
    exp_s.nph = 8'h10; exp_s.inf = 6'b001000; cycle("init1_np");
    send(4'h6, 3'd0, 8'h00, 12'h000);
    exp_s.inf = 6'b111000; exp_s.st = 2'b10; exp_s.typ = 4'hC; cycle("init1_cpl");
    dl.tx_init_ack = 1'b1; exp_s.typ = 4'hD; cycle("ack_c");

    // Wrong VC must not advance to ACTIVE nor change limits
    send(4'h8, 3'd1, 8'h77, 12'h777); cycle("wrong_vc");

    // Entry to ACTIVE via UpdateFC
    send(4'h8, 3'd0, 8'h25, 12'h0A0);
    exp_s.st = 2'b11; exp_s.done = 1'b1; exp_s.ph = 8'h25; exp_s.pd = 12'h0A0;
    exp_s.req = 1'b0; exp_s.typ = 4'h0;
    cycle("upd_to_active");

    send(4'h A, 3'd0, 8'h03, 12'h000); exp_s.err = 1'b1; cycle("upd_cpl_inf");
    cycle("err_pulse_end");
    send(4'h9, 3'd0, 8'h11, 12'h005);
    exp_s.err = 1'b1; exp_s.nph = 8'h11; cycle("upd_np_inf_data");

    // Link drop with a simultaneous DLLP
    link_up = 1'b0;
    send(4'h8, 3'd0, 8'h30, 12'h030);
    clear_exp();
    cycle("link_drop");
    link_up = 1'b1;
    exp_s.st = 2'b01; exp_s.req = 1'b1; exp_s.typ = 4'h4; cycle("relink");

    // Second bring-up with all-finite credits; ACTIVE entered via InitFC2
    send(4'h4, 3'd0, 8'h40, 12'h080);
    exp_s.ph = 8'h40; exp_s.pd = 12'h080; cycle("re_init1_p");
    send(4'hD, 3'd0, 8'h10, 12'h040);
    exp_s.nph = 8'h10; exp_s.npd = 12'h040; cycle("re_init2_np_in_init1");
    send(4'h6, 3'd0, 8'h08, 12'h100);
    exp_s.ch = 8'h08; exp_s.cd = 12'h100; exp_s.st = 2'b10; exp_s.typ = 4'hC;
    cycle("re_init1_cpl");
    send(4'h4, 3'd0, 8'h99, 12'h999); cycle("init1_in_init2");
    send(4'hD, 3'd0, 8'h66, 12'h666);
    exp_s.st = 2'b11; exp_s.done = 1'b1; exp_s.req = 1'b0; exp_s.typ = 4'h0;
    cycle("init2_to_active");
    send(4'h4, 3'd0, 8'h99, 12'h999); cycle("init1_in_active");

    // Wrap-around: no monotonic check
    send(4'h9, 3'd0, 8'hFF, 12'hFFF);
    exp_s.nph = 8'hFF; exp_s.npd = 12'hFFF; cycle("wrap_hi");
    send(4'h9, 3'd0, 8'h02, 12'h001);
    exp_s.nph = 8'h02; exp_s.npd = 12'h001; cycle("wrap_lo");

    // Reset overrides everything
    rst = 1'b1;
    clear_exp();
    cycle("rst_active");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_credit_limit_tracker.md
Name: fc_credit_limit_tracker

Overview:
- Receive-side flow-control tracker for VC0.
- Decodes InitFC1, InitFC2 and UpdateFC DLLPs from the data link layer and runs the FC initialisation state machine.
- Holds the six credit-limit registers (PH, PD, NPH, NPD, CH, CD) plus infinite-credit flags, and drives the credit-limit inputs of the TX flow-control gating logic.
- Paces InitFC transmit requests to the DLLP transmitter during initialisation.

Parameters:
- HDR_W, 8, header credit field width.
- DAT_W, 12, data credit field width.
- VC_ID, 3'd0, VC whose DLLPs are accepted.
- RESEND_CYC, 64, idle cycles between InitFC resend rounds; minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- link_up  in  1  DL_Up from the link layer. 0 forces IDLE.
- dllp_valid  in  1  one-cycle strobe; DLLP fields valid.
- dllp_type  in  4  4=InitFC1_P, 5=InitFC1_NP, 6=InitFC1_Cpl, C=InitFC2_P, D=InitFC2_NP, E=InitFC2_Cpl, 8=UpdateFC_P, 9=UpdateFC_NP, A=UpdateFC_Cpl; other codes ignored.
- dllp_vc  in  3  VC of the DLLP.
- dllp_hdr_fc  in  HDR_W  HdrFC field.
- dllp_data_fc  in  DAT_W  DataFC field.
- tx_init_ack  in  1  DLLP transmitter accepted the current request.
- PH_credit_limit, NPH_credit_limit, CH_credit_limit  out  HDR_W  header limits.
- PD_credit_limit, NPD_credit_limit, CD_credit_limit  out  DAT_W  data limits.
- inf_flags  out  6  {CD,CH,NPD,NPH,PD,PH}; 1 = infinite credits.
- fc_init_done  out  1  high in ACTIVE only.
- fc_state  out  2  00 IDLE, 01 INIT1, 10 INIT2, 11 ACTIVE.
- tx_init_req  out  1  request to send an InitFC DLLP.
- tx_init_type  out  4  type code to send (4/5/6 in INIT1, C/D/E in INIT2).
- protocol_err  out  1  one-cycle pulse on a malformed or unexpected DLLP.

Behaviour:
- Reset values: all limits 0, inf_flags 0, fc_state IDLE, fc_init_done 0, tx_init_req 0, tx_init_type 0, protocol_err 0.
- DLLP acceptance: a DLLP is used only when dllp_valid=1 and dllp_vc==VC_ID. All register updates take effect on the next clock edge; limit latency is 1 cycle.
- IDLE:
  - Limits, inf_flags and the recorded mask are cleared.
  - link_up=1 -> INIT1.
- INIT1:
  - An InitFC1 or InitFC2 of class X for which X is not yet recorded loads that class's hdr and data limits.
  - The same DLLP sets the inf flag of each field that is 0, and sets recorded[X].
  - A repeat of an already-recorded class is ignored; no value change.
  - UpdateFC -> protocol_err pulse, ignored.
  - When recorded==3'b111 (including the cycle the third class lands) -> INIT2.
- INIT2:
  - Any accepted InitFC2 or UpdateFC -> ACTIVE.
  - An UpdateFC arriving in INIT2 is also applied as in ACTIVE, in the same cycle.
  - InitFC1 is ignored.
- ACTIVE:
  - UpdateFC of class X overwrites the non-infinite fields of X. Infinite fields stay 0.
  - A non-zero value on an infinite field -> protocol_err; the other field of the DLLP is still applied.
  - Values are taken modulo 2^width with no monotonic check.
  - InitFC1 and InitFC2 are ignored.
- link_up=0 in any state -> IDLE on the next edge. This overrides a simultaneous DLLP.
- rst overrides everything.
- TX pacing sub-FSM (active in INIT1/INIT2 only):
  - Sends P, NP, Cpl in order. tx_init_req stays high with a stable tx_init_type until a cycle with tx_init_ack=1.
  - The next class is presented on the following cycle.
  - After the Cpl ack, tx_init_req=0 for RESEND_CYC cycles, then the round restarts at P.
  - The type set follows the current state. On an INIT1->INIT2 transition the sequence restarts at P with code C, and the resend counter is cleared.
  - In ACTIVE or IDLE: tx_init_req=0 and the counter is cleared.
- fc_init_done equals (fc_state==ACTIVE) and is registered.

Test Plan:
- Reset and bring-up: rst=1 for 2 cycles, link_up=1 -> fc_state=01; tx_init_req=1 with type 4; ack -> type 5; ack -> type 6; ack -> req=0 for 64 cycles, then type 4 again.
- Initialisation values: InitFC1_P hdr=0x20 data=0x080, InitFC1_NP hdr=0x10 data=0, InitFC1_Cpl hdr=0 data=0 -> PH=0x20, PD=0x080, NPH=0x10, inf_flags=6'b111000, fc_state=10 on the edge after the third DLLP; tx_init_type=C.
- Entry to ACTIVE: in INIT2, UpdateFC_P hdr=0x25 data=0x0A0 -> the next cycle shows fc_state=11, fc_init_done=1, PH=0x25, PD=0x0A0, tx_init_req=0.
- Filtering: dllp_vc=1 UpdateFC_P -> no change. A duplicate InitFC1_P in INIT1 with hdr=0x55 -> PH unchanged. UpdateFC_Cpl hdr=3 with CH infinite -> protocol_err pulses 1 cycle and CH stays 0.
- Link drop: link_up=0 in the same cycle as UpdateFC_P hdr=0x30 -> the next cycle shows fc_state=00, all limits 0, inf_flags=0. Re-raising link_up restarts INIT1 with type 4.
- Wrap-around: in ACTIVE, UpdateFC_NP hdr=0xFF data=0xFFF, then hdr=0x02 data=0x001 -> NPH=0x02, NPD=0x001, no error.
